// File: rtl/balance_pkg.sv
// Shared constants and saturating helpers for the balance controller.
package balance_pkg;

  // Default loop coefficients and torque-shaping constants.
  localparam int P_COEFF_DEF         = 14;
  localparam int D_COEFF_DEF         = 20;
  localparam int LOW_TORQUE_BAND_DEF = 70;
  localparam int GAIN_MULT_DEF       = 15;
  localparam int MIN_DUTY_DEF        = 980;

  // Wide signed carrier used by the helpers; every datapath value fits.
  typedef logic signed [63:0] wide_t;

  // Clamp x into the signed range of a w-bit two's complement number.
  function automatic wide_t saturate(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Magnitude of x, clamped to the largest w-bit unsigned value.
  function automatic logic [63:0] abs_clamp(input wide_t x, input int unsigned w);
    wide_t mag;
    wide_t lim;
    mag = (x < 0) ? -x : x;
    lim = (wide_t'(1) <<< w) - wide_t'(1);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/balance_cntrl_gen_torque_shaper.sv
// Torque shaper: low-torque gain or minimum-duty offset, then sign/magnitude split.
module torque_shaper
  import balance_pkg::*;
#(
  parameter int IN_W     = 36,
  parameter int SPD_W    = 11,
  parameter int BAND     = LOW_TORQUE_BAND_DEF,
  parameter int GAIN     = GAIN_MULT_DEF,
  parameter int MIN_DUTY = MIN_DUTY_DEF
) (
  input  logic signed [IN_W-1:0]  t,
  output logic        [SPD_W-1:0] spd,
  output logic                    rev
);

  wide_t t_w;
  wide_t shaped;

  // Shape the torque demand and split it into reverse flag and clamped speed.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path
    // (defaults first), otherwise synthesis infers a latch.
    t_w    = wide_t'(t);
    shaped = '0;
    if (t_w >= wide_t'(BAND) || t_w <= -wide_t'(BAND)) begin
      shaped = (t_w < 0) ? t_w - wide_t'(MIN_DUTY) : t_w + wide_t'(MIN_DUTY);
    end else begin
      shaped = t_w * wide_t'(GAIN);
    end
    rev = (shaped < 0);
    spd = SPD_W'(abs_clamp(shaped, SPD_W));
  end

endmodule

// File: rtl/balance_cntrl_gen.sv
// Two-stage PID balance controller: stage 1 captures error, history and
// integrator; stage 2 registers the shaped left/right motor commands.
module balance_cntrl_gen
  import balance_pkg::*;
#(
  parameter int PTCH_W          = 16,
  parameter int LD_W            = 12,
  parameter int SPD_W           = 11,
  parameter int ERR_W           = 10,
  parameter int INT_W           = 18,
  parameter int I_SHIFT         = 6,
  parameter int D_DEPTH         = 2,
  parameter int P_COEFF         = P_COEFF_DEF,
  parameter int D_COEFF         = D_COEFF_DEF,
  parameter int STEER_SHIFT     = 3,
  parameter int LOW_TORQUE_BAND = LOW_TORQUE_BAND_DEF,
  parameter int GAIN_MULT       = GAIN_MULT_DEF,
  parameter int MIN_DUTY        = MIN_DUTY_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic signed [LD_W-1:0]  ld_cell_diff,
  input  logic                    rider_off,
  input  logic                    en_steer,
  output logic        [SPD_W-1:0] lft_spd,
  output logic                    lft_rev,
  output logic        [SPD_W-1:0] rght_spd,
  output logic                    rght_rev,
  output logic                    out_vld
);

  localparam int PID_W = ERR_W + INT_W + 8;
  typedef logic signed [PID_W-1:0] pid_t;

  // Stage 1 state. hist[0] is the current error; hist[D_DEPTH] is the
  // sample the derivative is taken against.
  logic signed [ERR_W-1:0] hist_q [0:D_DEPTH];
  logic signed [ERR_W-1:0] hist_d [0:D_DEPTH];
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [INT_W-1:0] i_src_q, i_src_d;   // integrator as seen by this sample
  logic signed [LD_W-1:0]  ld_q, ld_d;
  logic                    steer_q, steer_d;
  logic                    s1_vld_q, s1_vld_d;
  logic                    s1_off_q, s1_off_d;

  // Stage 2 state.
  logic [SPD_W-1:0] lft_spd_q, lft_spd_d, rght_spd_q, rght_spd_d;
  logic             lft_rev_q, lft_rev_d, rght_rev_q, rght_rev_d;
  logic             out_vld_q, out_vld_d;

  logic signed [ERR_W-1:0] err_in;
  wide_t                   integ_sum;
  logic signed [6:0]       diff7;
  pid_t                    pid, steer, lft_t, rght_t;
  logic [SPD_W-1:0]        l_spd, r_spd;
  logic                    l_rev, r_rev;

  // Stage 1 next state: rider_off clears, vld captures, otherwise hold.
  always_comb begin
    hist_d    = hist_q;
    integ_d   = integ_q;
    i_src_d   = i_src_q;
    ld_d      = ld_q;
    steer_d   = steer_q;
    s1_vld_d  = 1'b0;
    s1_off_d  = rider_off;
    err_in    = ERR_W'(saturate(64'(ptch), ERR_W));
    integ_sum = wide_t'(integ_q) + wide_t'(err_in);
    if (rider_off) begin
      for (int k = 0; k <= D_DEPTH; k++) hist_d[k] = '0;
      integ_d = '0;
      i_src_d = '0;
    end else if (vld) begin
      hist_d[0] = err_in;
      for (int k = 1; k <= D_DEPTH; k++) hist_d[k] = hist_q[k-1];
      i_src_d  = integ_q;
      integ_d  = INT_W'(saturate(integ_sum, INT_W));
      ld_d     = ld_cell_diff;
      steer_d  = en_steer;
      s1_vld_d = 1'b1;
    end
  end

  // Stage 1 registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so all flops sample pre-edge values together.
    if (rst) begin
      // NOTE: the history array is reset explicitly because the derivative
      // reads it as zero until it fills; it is a few flops, not a RAM.
      for (int k = 0; k <= D_DEPTH; k++) hist_q[k] <= '0;
      integ_q  <= '0;
      i_src_q  <= '0;
      ld_q     <= '0;
      steer_q  <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_off_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      integ_q  <= integ_d;
      i_src_q  <= i_src_d;
      ld_q     <= ld_d;
      steer_q  <= steer_d;
      s1_vld_q <= s1_vld_d;
      s1_off_q <= s1_off_d;
    end
  end

  // PID sum and steering split from the stage 1 registers.
  always_comb begin
    diff7  = 7'(saturate(wide_t'(hist_q[0]) - wide_t'(hist_q[D_DEPTH]), 7));
    pid    = pid_t'(P_COEFF) * pid_t'(hist_q[0])
           + (pid_t'(i_src_q) >>> I_SHIFT)
           + pid_t'(D_COEFF) * pid_t'(diff7);
    steer  = pid_t'(ld_q) >>> STEER_SHIFT;
    lft_t  = steer_q ? pid - steer : pid;
    rght_t = steer_q ? pid + steer : pid;
  end

  torque_shaper #(
    .IN_W(PID_W), .SPD_W(SPD_W), .BAND(LOW_TORQUE_BAND),
    .GAIN(GAIN_MULT), .MIN_DUTY(MIN_DUTY)
  ) u_shape_lft (
    .t(lft_t), .spd(l_spd), .rev(l_rev)
  );

  torque_shaper #(
    .IN_W(PID_W), .SPD_W(SPD_W), .BAND(LOW_TORQUE_BAND),
    .GAIN(GAIN_MULT), .MIN_DUTY(MIN_DUTY)
  ) u_shape_rght (
    .t(rght_t), .spd(r_spd), .rev(r_rev)
  );

  // Stage 2 next state: rider off forces zero, a valid sample loads, else hold.
  always_comb begin
    lft_spd_d  = lft_spd_q;
    lft_rev_d  = lft_rev_q;
    rght_spd_d = rght_spd_q;
    rght_rev_d = rght_rev_q;
    out_vld_d  = 1'b0;
    if (s1_off_q) begin
      lft_spd_d  = '0;
      lft_rev_d  = 1'b0;
      rght_spd_d = '0;
      rght_rev_d = 1'b0;
    end else if (s1_vld_q) begin
      lft_spd_d  = l_spd;
      lft_rev_d  = l_rev;
      rght_spd_d = r_spd;
      rght_rev_d = r_rev;
      out_vld_d  = 1'b1;
    end
  end

  // Stage 2 output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_spd_q  <= '0;
      lft_rev_q  <= 1'b0;
      rght_spd_q <= '0;
      rght_rev_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      lft_spd_q  <= lft_spd_d;
      lft_rev_q  <= lft_rev_d;
      rght_spd_q <= rght_spd_d;
      rght_rev_q <= rght_rev_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign lft_spd  = lft_spd_q;
  assign lft_rev  = lft_rev_q;
  assign rght_spd = rght_spd_q;
  assign rght_rev = rght_rev_q;
  assign out_vld  = out_vld_q;

endmodule

// File: tb/tb_balance_cntrl_gen.sv
// Scoreboard bench for balance_cntrl_gen: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every out_vld.
module tb_balance_cntrl_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               vld;
  logic signed [15:0] ptch;
  logic signed [11:0] ld_cell_diff;
  logic               rider_off;
  logic               en_steer;
  logic [10:0]        lft_spd, rght_spd;
  logic               lft_rev, rght_rev;
  logic               out_vld;

  typedef struct packed {
    logic [10:0] ls;
    logic        lr;
    logic [10:0] rs;
    logic        rr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  always #5 clk = ~clk;

  balance_cntrl_gen dut (
    .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ld_cell_diff(ld_cell_diff),
    .rider_off(rider_off), .en_steer(en_steer),
    .lft_spd(lft_spd), .lft_rev(lft_rev), .rght_spd(rght_spd), .rght_rev(rght_rev),
    .out_vld(out_vld)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one valid sample and queue its expected result.
  task automatic send(input logic [15:0] p, input logic [11:0] ld, input logic st,
                      input int ls, input int lr, input int rs, input int rr);
    exp_t e;
    ptch = p; ld_cell_diff = ld; en_steer = st; vld = 1'b1;
    e.ls = 11'(ls); e.lr = lr[0]; e.rs = 11'(rs); e.rr = rr[0];
    exp_q.push_back(e);
    n_pushed++;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One-cycle rider_off pulse; the following edge must force zero outputs.
  task automatic rider_pulse(input string tag);
    rider_off = 1'b1;
    @(posedge clk); #1;
    rider_off = 1'b0;
    @(posedge clk); #1;
    check({tag, "_spd"}, {10'd0, lft_spd, rght_spd}, 32'd0);
    check({tag, "_rev_vld"}, {29'd0, lft_rev, rght_rev, out_vld}, 32'd0);
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_vld", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_popped++;
        check("scoreboard", 32'({lft_spd, lft_rev, rght_spd, rght_rev}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vld = 1'b1; ptch = 16'sh0100; ld_cell_diff = '0;
    rider_off = 1'b0; en_steer = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_spd", {10'd0, lft_spd, rght_spd}, 32'd0);
    check("reset_rev_vld", {29'd0, lft_rev, rght_rev, out_vld}, 32'd0);
    rst = 1'b0; vld = 1'b0; ptch = '0;
    idle(3);

    // Back-to-back from a clear state: history fills, third hits band edge t=70.
    send(16'h0005, 12'h000, 1'b0, 1150, 0, 1150, 0);
    send(16'h0005, 12'h000, 1'b0, 1150, 0, 1150, 0);
    send(16'h0005, 12'h000, 1'b0, 1050, 0, 1050, 0);

    // Rider off clears history: err=-1 then gives PID=-34 -> -510.
    rider_pulse("rider1");
    send(16'hFFFF, 12'h000, 1'b0, 510, 1, 510, 1);
    idle(3);

    // Reset lands while a sample is in flight: no out_vld, outputs zero.
    ptch = 16'sh0005; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_vld", {31'd0, out_vld}, 32'd0);
    idle(3);
    check("midrst_spd", {10'd0, lft_spd, rght_spd}, 32'd0);

    // Steering with zero pitch, including arithmetic shift of negatives.
    send(16'h0000, 12'h040, 1'b1, 120, 1, 120, 0);
    send(16'h0000, 12'hFC0, 1'b1, 120, 0, 120, 1);
    send(16'h0000, 12'h7FF, 1'b1, 1235, 1, 1235, 0);
    send(16'h0000, 12'hFFF, 1'b1, 15, 0, 15, 1);
    send(16'h0000, 12'h7FF, 1'b0, 0, 0, 0, 0);
    idle(3);

    // Positive saturation; then I=2047, D=-1280 proves no wrap.
    for (int i = 0; i < 300; i++) send(16'h7FFF, 12'h000, 1'b0, 2047, 0, 2047, 0);
    send(16'h0000, 12'h000, 1'b0, 1747, 0, 1747, 0);
    rider_pulse("rider2");

    // Negative saturation; then I=-2048, D=+1260 -> PID=-788 -> -1768.
    for (int i = 0; i < 300; i++) send(16'h8000, 12'h000, 1'b0, 2047, 1, 2047, 1);
    send(16'h0000, 12'h000, 1'b0, 1768, 1, 1768, 1);

    // Rider off then restart: integrator and history both read zero.
    rider_pulse("rider3");
    send(16'h0000, 12'h000, 1'b0, 0, 0, 0, 0);
    send(16'h0005, 12'h000, 1'b0, 1150, 0, 1150, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check("drain", 32'(exp_q.size()), 32'd0);
    check("pushed_vs_popped", 32'(n_popped), 32'(n_pushed));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/balance_cntrl_gen.md
Name: balance_cntrl_gen

Overview:
- Parametrised next-generation balance controller for the self-balancing platform.
- Converts the signed pitch sample from the inertial interface and the load-cell difference into left/right motor speed magnitude plus reverse flags, using PID control.
- New over the current controller:
  - parametrised widths and coefficients;
  - derivative history of configurable depth;
  - saturating integrator;
  - a registered output-valid strobe;
  - a steering-gain shift.

Parameters:
PTCH_W, 16, width of signed pitch input
LD_W, 12, width of signed load-cell difference
SPD_W, 11, width of unsigned speed magnitude outputs
ERR_W, 10, signed width pitch error is saturated to
INT_W, 18, signed integrator width (saturating)
I_SHIFT, 6, arithmetic right shift applied to integrator for I term
D_DEPTH, 2, number of valid samples back used for derivative (1..8)
P_COEFF, 14, proportional gain
D_COEFF, 20, derivative gain
STEER_SHIFT, 3, arithmetic right shift on ld_cell_diff for steering
LOW_TORQUE_BAND, 70, magnitude threshold for low-torque shaping
GAIN_MULT, 15, multiplier applied inside low-torque band
MIN_DUTY, 980, offset added outside low-torque band

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
vld  in  1  one-cycle strobe, ptch valid
ptch  in  PTCH_W  signed pitch
ld_cell_diff  in  LD_W  signed left-right load difference
rider_off  in  1  no rider present
en_steer  in  1  steering enabled
lft_spd  out  SPD_W  left speed magnitude
lft_rev  out  1  left reverse
rght_spd  out  SPD_W  right speed magnitude
rght_rev  out  1  right reverse
out_vld  out  1  one-cycle strobe, outputs updated

Behaviour:
- Reset (rst high at a clk edge):
  - all outputs become 0;
  - integrator, error register and history become 0.
- Stage 1, registered on the clk edge where vld=1:
  - err = ptch saturated to signed ERR_W;
  - history shifts: hist[0]=err, hist[k]=hist[k-1];
  - integrator += sign-extended err, saturating at the INT_W signed limits (no wrap).
- vld=0: stage 1 holds all state.
- Derivative:
  - D = D_COEFF * sat7(err - hist[D_DEPTH]);
  - the difference is saturated to signed 7 bits before the multiply;
  - history entries are 0 until filled.
- PID = P_COEFF*err + (integrator >>> I_SHIFT) + D.
  - Compute at ERR_W+INT_W+8 bits; no intermediate overflow is permitted.
- Steering:
  - en_steer=1: lft = PID - (ld_cell_diff >>> STEER_SHIFT), rght = PID + (ld_cell_diff >>> STEER_SHIFT);
  - en_steer=0: both equal PID.
- Shaping, per side, on value t:
  - |t| >= LOW_TORQUE_BAND: t + sign(t)*MIN_DUTY;
  - otherwise: t*GAIN_MULT.
  - rev = 1 iff the shaped value is < 0.
  - spd = |shaped| clamped to 2^SPD_W-1.
- Stage 2: outputs are registered one cycle after stage 1. out_vld=1 exactly 2 cycles after the vld pulse.
  - Total latency from vld to new outputs is 2 edges.
- Back-to-back vld (every cycle): fully pipelined; one result per cycle.
- rider_off=1, sampled every cycle, takes priority over vld:
  - integrator and history clear to 0 on that edge;
  - next edge forces spd=0, rev=0, out_vld=0;
  - on its deassertion, the controller restarts from a cleared state.
- rst asserted mid-pipeline: in-flight results are discarded; out_vld stays 0.
- Negative saturation: integrator minimum is -2^(INT_W-1); err minimum is -2^(ERR_W-1).

Decomposition:
- Package balance_pkg holds:
  - default coefficient constants: P_COEFF, D_COEFF, LOW_TORQUE_BAND, GAIN_MULT, MIN_DUTY;
  - a saturate function (signed in width, out width);
  - an abs_clamp function.
- One sub-module, torque_shaper: shaping plus sign/magnitude clamp. It is instantiated twice, once for left and once for right.

Test Plan:
- Reset: rst=1 for 2 cycles with ptch=16'h0100, vld=1 -> all outputs 0, out_vld 0.
- Single sample, defaults, en_steer=0, ptch=16'h0005 after reset:
  - err=5, P=70, I=0, D=20*5=100, PID=170;
  - shaped = 170+980 = 1150, clamped to 2047? No, 1150 < 2047;
  - expect lft_spd=rght_spd=1150, rev=0, out_vld at cycle 2.
- Small negative, ptch=16'hFFFF (err=-1) from reset:
  - PID = -14 + 0 + -20 = -34;
  - |t| < 70, shaped = -510;
  - expect spd=510, rev=1 on both sides.
- Saturation, ptch=16'h7FFF repeated 300 vld cycles:
  - err = 511;
  - integrator stops at 131071, never wraps negative;
  - spd=2047, rev=0 throughout.
- Steering, ptch=0 steady, en_steer=1, ld_cell_diff=12'h040 (64>>>3=8):
  - lft t = -8 -> spd 120, rev 1;
  - rght t = 8 -> spd 120, rev 0.
- Rider off: mid-stream, rider_off=1 for 1 cycle -> next cycle spd=0, out_vld=0; the integrator reads 0 at the next vld.
